// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded control and operands, inserts bubbles on
// load-use hazards and flushes, and counts load-use bubbles with a saturating counter.
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              res,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [10:0]       id_ctrl,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [5:0]        id_funct,
    output logic              ex_valid,
    output logic [10:0]       ex_ctrl,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [RA_W-1:0]   ex_rs,
    output logic [RA_W-1:0]   ex_rt,
    output logic [RA_W-1:0]   ex_rd,
    output logic [5:0]        ex_funct,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int unsigned CTRL_W      = 11;
    localparam int unsigned FUNCT_W     = 6;
    localparam int unsigned MEMREAD_BIT = 4;
    localparam int unsigned JUMP_BIT    = 0;

    logic              valid_q,   valid_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [DATA_W-1:0] pc4_q,     pc4_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [RA_W-1:0]   rs_q,      rs_d;
    logic [RA_W-1:0]   rt_q,      rt_d;
    logic [RA_W-1:0]   rd_q,      rd_d;
    logic [FUNCT_W-1:0] funct_q,  funct_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic              hazard;
    logic [CTRL_W-1:0] ctrl_san;

    // Load in EX whose destination is a source of the instruction waiting in ID
    assign hazard = id_valid & valid_q & ctrl_q[MEMREAD_BIT] & (rt_q != RA_W'(0))
                    & ((rt_q == id_rs) | (rt_q == id_rt));

    // Jumps only need the Jump bit; dropping the rest keeps decoder don't-cares out of EX
    assign ctrl_san = id_ctrl[JUMP_BIT] ? CTRL_W'(1) : id_ctrl;

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        pc4_d     = pc4_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        funct_d   = funct_q;
        cnt_d     = cnt_q;

        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_W'(0);
        end else if (stall) begin
            valid_d = valid_q;
        end else if (hazard) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_W'(0);
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            valid_d   = id_valid;
            ctrl_d    = id_valid ? ctrl_san : CTRL_W'(0);
            pc4_d     = id_pc4;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
            rs_d      = id_rs;
            rt_d      = id_rt;
            rd_d      = id_rd;
            funct_d   = id_funct;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_W'(0);
            pc4_q     <= DATA_W'(0);
            rs_data_q <= DATA_W'(0);
            rt_data_q <= DATA_W'(0);
            imm_q     <= DATA_W'(0);
            rs_q      <= RA_W'(0);
            rt_q      <= RA_W'(0);
            rd_q      <= RA_W'(0);
            funct_q   <= FUNCT_W'(0);
            cnt_q     <= CNT_W'(0);
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            pc4_q     <= pc4_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            funct_q   <= funct_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_ctrl        = ctrl_q;
    assign ex_pc4         = pc4_q;
    assign ex_rs_data     = rs_data_q;
    assign ex_rt_data     = rt_data_q;
    assign ex_imm         = imm_q;
    assign ex_rs          = rs_q;
    assign ex_rt          = rt_q;
    assign ex_rd          = rd_q;
    assign ex_funct       = funct_q;
    assign load_use_stall = hazard;
    assign bubble_cnt     = cnt_q;

endmodule
